// File: rtl/riscv_blk_wb_pkg.sv
// riscv_blk_wb_pkg
//   Shared types and derived-constant helpers for the block write-back unit.
//   The unit writes a wide result block (e.g. an AES state) to memory as a
//   sequence of word-wide OBI-style write beats.
//   Contents:
//     wb_state_e    - write-back FSM state encoding
//     calc_nbeats   - NBEATS = BLK_W / WORD_W
//     calc_off_w    - byte-offset width of a word address, log2(WORD_W/8)
//     calc_beat_w   - beat counter width (at least 1 bit)
//     calc_outst_w  - outstanding-response counter width, clog2(NBEATS+1)
package riscv_blk_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

  localparam int BLK_W_DEF  = 128;
  localparam int WORD_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  function automatic int calc_nbeats(input int blk_w, input int word_w);
    return blk_w / word_w;
  endfunction

  function automatic int calc_off_w(input int word_w);
    return $clog2(word_w / 8);
  endfunction

  function automatic int calc_beat_w(input int nbeats);
    return (nbeats > 1) ? $clog2(nbeats) : 1;
  endfunction

  function automatic int calc_outst_w(input int nbeats);
    return $clog2(nbeats + 1);
  endfunction

endpackage

// File: rtl/riscv_blk_wb.sv
// riscv_blk_wb
//   Writes a BLK_W-bit result block to memory as NBEATS word writes over an
//   OBI-style request/grant/response port, stalling the core while busy.
//   Optional build macro: RISCV_BLK_WB_BSWAP_EN - byte-reverse every word
//   before it is driven on mem_wdata_o (AES state byte order).
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     start_i         write-back request (sampled in IDLE only)
//     addr_i          base byte address (must be word aligned)
//     data_i          result block, word k = data_i[k*WORD_W +: WORD_W]
//     ready_o         idle indication
//     halt_o          core stall request (WRITE and DRAIN)
//     done_o          one-cycle completion pulse
//     err_o           one-cycle misaligned-address pulse
//     mem_req_o       memory request
//     mem_we_o        write enable (equal to mem_req_o)
//     mem_be_o        byte enables (all ones while requesting)
//     mem_addr_o      word byte address
//     mem_wdata_o     write data
//     mem_gnt_i       grant; a beat transfers on mem_req_o & mem_gnt_i
//     mem_rvalid_i    write response, one per granted beat
module riscv_blk_wb
  import riscv_blk_wb_pkg::*;
#(
  parameter int BLK_W  = BLK_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [BLK_W-1:0]    data_i,
  output logic                ready_o,
  output logic                halt_o,
  output logic                done_o,
  output logic                err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [WORD_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [WORD_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i
);

  localparam int NBEATS  = calc_nbeats(BLK_W, WORD_W);
  localparam int NBYTES  = WORD_W / 8;
  localparam int OFF_W   = calc_off_w(WORD_W);
  localparam int BEAT_W  = calc_beat_w(NBEATS);
  localparam int OUTST_W = calc_outst_w(NBEATS);

  localparam logic [ADDR_W-1:0]  ADDR_STEP = ADDR_W'(NBYTES);
  localparam logic [ADDR_W-1:0]  OFF_MASK  = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic [OUTST_W-1:0] OUTST_ONE = OUTST_W'(1);

  // Word formatting applied on the way to the bus.
  function automatic logic [WORD_W-1:0] fmt_word(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
`ifdef RISCV_BLK_WB_BSWAP_EN
    r = '0;
    for (int b = 0; b < NBYTES; b++) begin
      r[b*8 +: 8] = w[(NBYTES-1-b)*8 +: 8];
    end
`else
    r = w;
`endif
    return r;
  endfunction

  wb_state_e           state_r;
  logic [BEAT_W-1:0]   beat_r;
  logic [BLK_W-1:0]    blk_r;
  logic [OUTST_W-1:0]  outst_r;
  logic                mem_req_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [WORD_W-1:0]   mem_wdata_r;
  logic                ready_r;
  logic                halt_r;
  logic                done_r;
  logic                err_r;

  logic                grant_s;
  logic                rsp_s;
  logic                aligned_s;
  logic                drain_exit_s;
  logic [BLK_W-1:0]    next_blk_s;
  logic [WORD_W-1:0]   next_word_s;

  // Handshake qualifiers and the next word to present after a grant.
  // The captured block is shifted down one word per grant, so the word on
  // the bus is always the low word of blk_r.
  always_comb begin
    grant_s      = mem_req_r & mem_gnt_i;
    rsp_s        = mem_rvalid_i & (outst_r != '0);
    aligned_s    = ((addr_i & OFF_MASK) == '0);
    drain_exit_s = (outst_r == '0) || ((outst_r == OUTST_ONE) && mem_rvalid_i);
    next_blk_s   = blk_r >> WORD_W;
    next_word_s  = fmt_word(next_blk_s[WORD_W-1:0]);
  end

  // Outstanding write responses: +1 per grant, -1 per response, and a
  // response with nothing outstanding (e.g. late after reset) is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_r <= '0;
    end else begin
      case ({grant_s, rsp_s})
        2'b10:   outst_r <= outst_r + OUTST_ONE;
        2'b01:   outst_r <= outst_r - OUTST_ONE;
        default: outst_r <= outst_r;
      endcase
    end
  end

  // Write-back FSM with all bus and status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      beat_r      <= '0;
      blk_r       <= '0;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      ready_r     <= 1'b1;
      halt_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          err_r  <= start_i & ~aligned_s;
          if (start_i && aligned_s) begin
            state_r     <= ST_WRITE;
            blk_r       <= data_i;
            beat_r      <= '0;
            mem_req_r   <= 1'b1;
            mem_addr_r  <= addr_i;
            mem_wdata_r <= fmt_word(data_i[WORD_W-1:0]);
            ready_r     <= 1'b0;
            halt_r      <= 1'b1;
          end
        end
        ST_WRITE: begin
          err_r <= 1'b0;
          if (grant_s) begin
            if (beat_r == LAST_BEAT) begin
              state_r     <= ST_DRAIN;
              mem_req_r   <= 1'b0;
              mem_addr_r  <= '0;
              mem_wdata_r <= '0;
            end else begin
              beat_r      <= beat_r + BEAT_W'(1);
              blk_r       <= next_blk_s;
              mem_addr_r  <= mem_addr_r + ADDR_STEP;  // wraps modulo 2^ADDR_W
              mem_wdata_r <= next_word_s;
            end
          end
        end
        ST_DRAIN: begin
          err_r <= 1'b0;
          if (drain_exit_s) begin
            state_r <= ST_DONE;
            halt_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          err_r   <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          mem_req_r   <= 1'b0;
          mem_addr_r  <= '0;
          mem_wdata_r <= '0;
          ready_r     <= 1'b1;
          halt_r      <= 1'b0;
          done_r      <= 1'b0;
          err_r       <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o     = ready_r;
  assign halt_o      = halt_r;
  assign done_o      = done_r;
  assign err_o       = err_r;
  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_req_r;
  assign mem_be_o    = {NBYTES{mem_req_r}};
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;

endmodule

// File: tb/tb_riscv_blk_wb.sv
// tb_riscv_blk_wb
//   Directed self-checking bench for riscv_blk_wb. Instance u_dut_a uses the
//   default geometry (128/32/32); u_dut_b uses a 256-bit block of 64-bit
//   words to exercise address wrap-around. The memory side grants as driven
//   by the stimulus and answers every grant with a response one cycle later.
module tb_riscv_blk_wb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic         a_start;
  logic [31:0]  a_addr;
  logic [127:0] a_data;
  logic         a_ready, a_halt, a_done, a_err, a_req, a_we;
  logic [3:0]   a_be;
  logic [31:0]  a_maddr;
  logic [31:0]  a_wdata;
  logic         a_gnt, a_rvalid;

  logic         b_start;
  logic [31:0]  b_addr;
  logic [255:0] b_data;
  logic         b_ready, b_halt, b_done, b_err, b_req, b_we;
  logic [7:0]   b_be;
  logic [31:0]  b_maddr;
  logic [63:0]  b_wdata;
  logic         b_gnt, b_rvalid;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  riscv_blk_wb u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(a_start), .addr_i(a_addr), .data_i(a_data),
    .ready_o(a_ready), .halt_o(a_halt), .done_o(a_done), .err_o(a_err),
    .mem_req_o(a_req), .mem_we_o(a_we), .mem_be_o(a_be), .mem_addr_o(a_maddr),
    .mem_wdata_o(a_wdata), .mem_gnt_i(a_gnt), .mem_rvalid_i(a_rvalid)
  );

  riscv_blk_wb #(.BLK_W(256), .WORD_W(64), .ADDR_W(32)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(b_start), .addr_i(b_addr), .data_i(b_data),
    .ready_o(b_ready), .halt_o(b_halt), .done_o(b_done), .err_o(b_err),
    .mem_req_o(b_req), .mem_we_o(b_we), .mem_be_o(b_be), .mem_addr_o(b_maddr),
    .mem_wdata_o(b_wdata), .mem_gnt_i(b_gnt), .mem_rvalid_i(b_rvalid)
  );

  function automatic logic [31:0] exp32(input logic [31:0] w);
`ifdef RISCV_BLK_WB_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [63:0] exp64(input logic [63:0] w);
`ifdef RISCV_BLK_WB_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24], w[39:32], w[47:40], w[55:48], w[63:56]};
`else
    return w;
`endif
  endfunction

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: responses follow each grant by exactly one cycle.
  task automatic tick();
    logic ga, gb;
    ga = a_req & a_gnt;
    gb = b_req & b_gnt;
    @(posedge clk);
    #1;
    a_rvalid = ga;
    b_rvalid = gb;
    cyc++;
  endtask

  task automatic chk_reset_a(input string tag);
    chk_eq({tag, "_ready"}, a_ready, 1);
    chk_eq({tag, "_halt"},  a_halt,  0);
    chk_eq({tag, "_done"},  a_done,  0);
    chk_eq({tag, "_err"},   a_err,   0);
    chk_eq({tag, "_req"},   a_req,   0);
    chk_eq({tag, "_we"},    a_we,    0);
    chk_eq({tag, "_be"},    a_be,    0);
    chk_eq({tag, "_addr"},  a_maddr, 0);
    chk_eq({tag, "_wdata"}, a_wdata, 0);
  endtask

  // Full transfer on u_dut_a; optional grant stall on one beat.
  task automatic run_wb(input string tag, input logic [31:0] base, input logic [127:0] blk,
                        input int stall_beat, input int stall_n, input int exp_done);
    int beat, stalls, t0;
    logic [31:0] words [4];
    words[0] = blk[31:0];
    words[1] = blk[63:32];
    words[2] = blk[95:64];
    words[3] = blk[127:96];
    a_start = 1'b1; a_addr = base; a_data = blk; a_gnt = 1'b1;
    t0 = cyc;
    tick();
    a_start = 1'b0; a_addr = 32'hDEAD_BEE0; a_data = ~blk;
    beat = 0; stalls = 0;
    for (int n = 0; n < 16 && beat < 4; n++) begin
      chk_eq($sformatf("%s_b%0d_req", tag, beat),   a_req, 1);
      chk_eq($sformatf("%s_b%0d_we", tag, beat),    a_we, 1);
      chk_eq($sformatf("%s_b%0d_be", tag, beat),    a_be, 4'hF);
      chk_eq($sformatf("%s_b%0d_addr", tag, beat),  a_maddr, base + 32'(4 * beat));
      chk_eq($sformatf("%s_b%0d_wdata", tag, beat), a_wdata, exp32(words[beat]));
      chk_eq($sformatf("%s_b%0d_halt", tag, beat),  a_halt, 1);
      if (beat == stall_beat && stalls < stall_n) begin
        a_gnt = 1'b0; stalls++;
      end else begin
        a_gnt = 1'b1; beat++;
      end
      tick();
    end
    a_gnt = 1'b1;
    chk_eq({tag, "_drain_req"},  a_req, 0);
    chk_eq({tag, "_drain_be"},   a_be, 0);
    chk_eq({tag, "_drain_halt"}, a_halt, 1);
    chk_eq({tag, "_drain_done"}, a_done, 0);
    tick();
    chk_eq({tag, "_done"},      a_done, 1);
    chk_eq({tag, "_done_cyc"},  64'(cyc - t0), 64'(exp_done));
    chk_eq({tag, "_done_halt"}, a_halt, 0);
    tick();
    chk_eq({tag, "_post_done"},  a_done, 0);
    chk_eq({tag, "_post_ready"}, a_ready, 1);
  endtask

  initial begin : stim
    logic [255:0] b_blk;
    logic [31:0]  b_exp_addr [4];
    int t0;

    rst_n = 1'b0;
    a_start = 1'b0; a_addr = '0; a_data = '0; a_gnt = 1'b0; a_rvalid = 1'b0;
    b_start = 1'b0; b_addr = '0; b_data = '0; b_gnt = 1'b0; b_rvalid = 1'b0;
    tick(); tick();
    chk_reset_a("rst");
    chk_eq("rst_b_ready", b_ready, 1);
    chk_eq("rst_b_req",   b_req, 0);
    rst_n = 1'b1;
    tick();

    // Reference transfer, no stalls.
    run_wb("base", 32'h0000_1000, 128'h33333333_22222222_11111111_00000000, -1, 0, 6);

    // Beat 1 held off for three cycles.
    run_wb("stall", 32'h0000_1000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1, 3, 9);

    // Misaligned base address.
    a_start = 1'b1; a_addr = 32'h0000_1002; a_data = 128'h1;
    tick();
    a_start = 1'b0;
    chk_eq("mis_err",   a_err, 1);
    chk_eq("mis_req",   a_req, 0);
    chk_eq("mis_halt",  a_halt, 0);
    chk_eq("mis_ready", a_ready, 1);
    tick();
    chk_eq("mis_err_1cyc", a_err, 0);
    chk_eq("mis_req_2",    a_req, 0);
    chk_eq("mis_halt_2",   a_halt, 0);

    // Reset while beat 2 is on the bus, with a stray response afterwards.
    a_start = 1'b1; a_addr = 32'h0000_2000; a_data = 128'h0F0F0F0F_0E0E0E0E_0D0D0D0D_0C0C0C0C;
    a_gnt = 1'b1;
    tick();
    a_start = 1'b0;
    tick(); tick();
    chk_eq("mid_b2_addr", a_maddr, 32'h0000_2008);
    rst_n = 1'b0;
    #1;
    chk_reset_a("midrst");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    a_rvalid = 1'b1;
    tick();
    chk_eq("stray_ready", a_ready, 1);
    chk_eq("stray_req",   a_req, 0);
    run_wb("after_rst", 32'h0000_2000, 128'h0F0F0F0F_0E0E0E0E_0D0D0D0D_0C0C0C0C, -1, 0, 6);

    // Byte-order sample word.
    run_wb("bo", 32'h0000_3000, 128'hCAFEF00D_89ABCDEF_01234567_00112233, -1, 0, 6);

    // Wide words and address wrap on u_dut_b; start_i stays high throughout.
    b_blk = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
    b_exp_addr[0] = 32'hFFFF_FFF0;
    b_exp_addr[1] = 32'hFFFF_FFF8;
    b_exp_addr[2] = 32'h0000_0000;
    b_exp_addr[3] = 32'h0000_0008;
    b_start = 1'b1; b_addr = 32'hFFFF_FFF0; b_data = b_blk; b_gnt = 1'b1;
    t0 = cyc;
    tick();
    b_data = '1; b_addr = 32'h0000_0100;
    for (int k = 0; k < 4; k++) begin
      chk_eq($sformatf("w_b%0d_req", k),   b_req, 1);
      chk_eq($sformatf("w_b%0d_be", k),    b_be, 8'hFF);
      chk_eq($sformatf("w_b%0d_addr", k),  b_maddr, b_exp_addr[k]);
      chk_eq($sformatf("w_b%0d_wdata", k), b_wdata, exp64(b_blk[k*64 +: 64]));
      tick();
    end
    chk_eq("w_drain_req",  b_req, 0);
    chk_eq("w_drain_halt", b_halt, 1);
    tick();
    b_start = 1'b0;
    chk_eq("w_done",     b_done, 1);
    chk_eq("w_done_cyc", 64'(cyc - t0), 64'(6));
    tick();
    chk_eq("w_post_ready", b_ready, 1);
    chk_eq("w_post_req",   b_req, 0);
    tick();
    chk_eq("w_idle_req", b_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_blk_wb.md
RISCV_BLK_WB -- requirements
Module: riscv_blk_wb

Interface
REQ-001 The parameter BLK_W SHALL default to 128 and set the width of the result block to write back.
REQ-002 The parameter WORD_W SHALL default to 32 and set the memory word width; BLK_W SHALL be an integer multiple of WORD_W; NBEATS = BLK_W/WORD_W.
REQ-003 The parameter ADDR_W SHALL default to 32 and set the byte address width.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  write-back request, sampled only in IDLE.
REQ-007 addr_i  input  ADDR_W  base byte address of the block.
REQ-008 data_i  input  BLK_W  result block; word k = data_i[k*WORD_W +: WORD_W].
REQ-009 ready_o  output  1  high only in IDLE.
REQ-010 halt_o  output  1  core stall request.
REQ-011 done_o  output  1  one-cycle completion pulse.
REQ-012 err_o  output  1  one-cycle misaligned-address pulse.
REQ-013 mem_req_o  output  1  memory request, OBI-style.
REQ-014 mem_we_o  output  1  write enable; SHALL equal mem_req_o.
REQ-015 mem_be_o  output  WORD_W/8  byte enables; all ones whenever mem_req_o is high, otherwise zero.
REQ-016 mem_addr_o  output  ADDR_W  word byte address.
REQ-017 mem_wdata_o  output  WORD_W  write data.
REQ-018 mem_gnt_i  input  1  grant; a beat transfers on mem_req_o & mem_gnt_i.
REQ-019 mem_rvalid_i  input  1  write response, one per granted beat.

Function
REQ-020 The FSM SHALL have the states IDLE, WRITE, DRAIN and DONE.
REQ-021 IDLE with start_i=1 and an aligned addr_i SHALL capture addr_i and data_i into internal registers, clear the beat counter and move to WRITE.
REQ-022 An address is aligned when addr_i[log2(WORD_W/8)-1:0]==0.
REQ-023 IDLE with start_i=1 and a misaligned addr_i SHALL stay in IDLE, issue no request and pulse err_o in the next cycle.
REQ-024 start_i outside IDLE SHALL be ignored, and data_i/addr_i changes after capture SHALL have no effect.
REQ-025 In WRITE, mem_req_o SHALL be 1, mem_addr_o SHALL be base + k*(WORD_W/8), and mem_wdata_o SHALL be captured word k, where k is the beat counter.
REQ-026 mem_addr_o, mem_wdata_o and mem_req_o SHALL be held stable until granted.
REQ-027 Each grant SHALL increment k; the grant of beat NBEATS-1 SHALL move WRITE to DRAIN, with mem_req_o low from the next cycle.
REQ-028 An outstanding counter of width clog2(NBEATS+1) SHALL count +1 per grant and -1 per mem_rvalid_i, with a simultaneous grant and rvalid leaving it unchanged.
REQ-029 mem_rvalid_i arriving when the outstanding counter is 0 SHALL be ignored, with no underflow.
REQ-030 DRAIN SHALL move to DONE when outstanding==0, or when outstanding==1 and mem_rvalid_i=1.
REQ-031 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-032 halt_o SHALL be 1 in WRITE and DRAIN, and 0 in IDLE and DONE.
REQ-033 Address arithmetic SHALL wrap modulo 2^ADDR_W.

Reset
REQ-034 On rst_n=0, at any time including mid-transfer, the FSM SHALL go to IDLE and clear the counters and registers.
REQ-035 On rst_n=0, the outputs SHALL be ready_o=1, and halt_o, done_o, err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o all 0.
REQ-036 Responses arriving after reset SHALL be ignored per REQ-029.

Configuration
REQ-037 With RISCV_BLK_WB_BSWAP_EN defined, each word SHALL be byte-reversed before driving mem_wdata_o (AES state byte order).
REQ-038 Without RISCV_BLK_WB_BSWAP_EN, words SHALL be driven unmodified.

Structure
REQ-039 The state enum and the derived constants (NBEATS, byte-offset width) SHALL live in package riscv_blk_wb_pkg.
REQ-040 The block SHALL be a single module with no sub-module; the optional swap SHALL be a generate/ifdef branch inside it.

Verification
REQ-041 Default parameters, gnt=1, rvalid one cycle after each grant, start at cycle T, addr=0x1000, data=0x33333333_22222222_11111111_00000000 -> writes at 0x1000/04/08/0C with data 0x0,0x11111111,0x22222222,0x33333333 in cycles T+1..T+4; done_o in T+6; halt_o in T+1..T+5.
REQ-042 gnt low for 3 cycles on beat 1 -> mem_addr_o=0x1004 and mem_wdata_o held for those cycles; done_o delayed by 3 cycles.
REQ-043 addr=0x1002 -> err_o in T+1, mem_req_o never asserted, halt_o stays 0.
REQ-044 rst_n low during beat 2 -> all outputs at reset values immediately; a new start afterwards writes all 4 beats from beat 0.
REQ-045 RISCV_BLK_WB_BSWAP_EN defined, word 0 = 0x00112233 -> mem_wdata_o=0x33221100.
REQ-046 BLK_W=256, WORD_W=64, addr=0xFFFFFFF0 -> 4 beats at 0xFFFFFFF0, 0xFFFFFFF8, 0x00000000, 0x00000008; start_i held high during the transfer is ignored.
